// File: rtl/countdown_timer.sv
// countdown_timer: loadable mm:ss BCD countdown toward 00:00.
//
// One count per internal tick. A tick is produced when the clock divider wraps,
// which happens every TICK_DIV cycles. Start, pause and load are sequenced by a
// four-state FSM, and done pulses for one cycle on expiry. bout toggles on every
// minute borrow.
//
// Optional feature: define COUNTDOWN_ALARM_EN to make alarm blink for
// ALARM_TICKS ticks after expiry. Without it, alarm stays 0 and the divider is
// idle in DONE.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | stopped; load captures the preset, start begins counting
// ST_RUN   | divider running; each tick decrements one second
// ST_PAUSE | divider and digits frozen; start resumes, load returns to IDLE
// ST_DONE  | reached 00:00; only load (or clr) leaves
module countdown_timer #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [2:0] set_mt,
    input  logic [3:0] set_mo,
    input  logic [2:0] set_st,
    input  logic [3:0] set_so,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] state,
    output logic       done,
    output logic       bout,
    output logic       alarm
);

    localparam int unsigned DIV_W  = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam int unsigned ACNT_W = (ALARM_TICKS > 0) ? $clog2(ALARM_TICKS + 1) : 1;
    localparam logic [ACNT_W-1:0] ACNT_LOAD = ACNT_W'(ALARM_TICKS);

`ifdef COUNTDOWN_ALARM_EN
    localparam logic ALARM_EN = 1'b1;
`else
    localparam logic ALARM_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [3:0]        mt_q, mt_d;
    logic [3:0]        mo_q, mo_d;
    logic [3:0]        st_q, st_d;
    logic [3:0]        so_q, so_d;
    logic              done_q, done_d;
    logic              bout_q, bout_d;
    logic              alarm_q, alarm_d;
    logic [ACNT_W-1:0] acnt_q, acnt_d;

    logic [3:0] ld_mt, ld_mo, ld_st, ld_so;
    logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
    logic       dec_min_borrow;
    logic       dec_zero;
    logic       digits_zero;
    logic       div_wrap;

    // Saturate the preset digits so the counter never holds a non-BCD/non-sexagesimal value.
    always_comb begin
        ld_mt = (set_mt > 3'd5) ? 4'd5 : {1'b0, set_mt};
        ld_mo = (set_mo > 4'd9) ? 4'd9 : set_mo;
        ld_st = (set_st > 3'd5) ? 4'd5 : {1'b0, set_st};
        ld_so = (set_so > 4'd9) ? 4'd9 : set_so;
    end

    // One-second decrement with borrow through sec ones -> sec tens -> min ones -> min tens.
    always_comb begin
        dec_mt         = mt_q;
        dec_mo         = mo_q;
        dec_st         = st_q;
        dec_so         = so_q;
        dec_min_borrow = 1'b0;
        if (so_q != 4'd0) begin
            dec_so = so_q - 4'd1;
        end else begin
            dec_so = 4'd9;
            if (st_q != 4'd0) begin
                dec_st = st_q - 4'd1;
            end else begin
                dec_st         = 4'd5;
                dec_min_borrow = 1'b1;
                if (mo_q != 4'd0) begin
                    dec_mo = mo_q - 4'd1;
                end else begin
                    dec_mo = 4'd9;
                    // RUN is never entered at 00:00, so this guard only keeps the tens digit sane.
                    if (mt_q != 4'd0) begin
                        dec_mt = mt_q - 4'd1;
                    end
                end
            end
        end
        dec_zero    = (dec_mt == 4'd0) && (dec_mo == 4'd0) && (dec_st == 4'd0) && (dec_so == 4'd0);
        digits_zero = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
        div_wrap    = (div_q == DIV_MAX);
    end

    // Next-state, divider, digit and output-flag logic.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        mt_d    = mt_q;
        mo_d    = mo_q;
        st_d    = st_q;
        so_d    = so_q;
        done_d  = 1'b0;
        bout_d  = bout_q;
        alarm_d = alarm_q;
        acnt_d  = acnt_q;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    mt_d = ld_mt;
                    mo_d = ld_mo;
                    st_d = ld_st;
                    so_d = ld_so;
                end else if (start && !pause) begin
                    div_d = '0;
                    if (digits_zero) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        alarm_d = 1'b0;
                        acnt_d  = ALARM_EN ? ACNT_LOAD : '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (pause) begin
                    state_d = ST_PAUSE;
                end else if (div_wrap) begin
                    div_d = '0;
                    mt_d  = dec_mt;
                    mo_d  = dec_mo;
                    st_d  = dec_st;
                    so_d  = dec_so;
                    if (dec_min_borrow) begin
                        bout_d = ~bout_q;
                    end
                    if (dec_zero) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        alarm_d = 1'b0;
                        acnt_d  = ALARM_EN ? ACNT_LOAD : '0;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            ST_PAUSE: begin
                if (load) begin
                    state_d = ST_IDLE;
                    mt_d    = ld_mt;
                    mo_d    = ld_mo;
                    st_d    = ld_st;
                    so_d    = ld_so;
                end else if (start && !pause) begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                if (load) begin
                    state_d = ST_IDLE;
                    mt_d    = ld_mt;
                    mo_d    = ld_mo;
                    st_d    = ld_st;
                    so_d    = ld_so;
                    div_d   = '0;
                    alarm_d = 1'b0;
                    acnt_d  = '0;
                end else if (ALARM_EN && (acnt_q != '0)) begin
                    // Even tick count leaves alarm low once the blink budget is spent.
                    if (div_wrap) begin
                        div_d   = '0;
                        alarm_d = ~alarm_q;
                        acnt_d  = acnt_q - ACNT_W'(1);
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            mt_q    <= 4'd0;
            mo_q    <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
            alarm_q <= 1'b0;
            acnt_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            mt_q    <= mt_d;
            mo_q    <= mo_d;
            st_q    <= st_d;
            so_q    <= so_d;
            done_q  <= done_d;
            bout_q  <= bout_d;
            alarm_q <= alarm_d;
            acnt_q  <= acnt_d;
        end
    end

    assign min_tens = mt_q;
    assign min_ones = mo_q;
    assign sec_tens = st_q;
    assign sec_ones = so_q;
    assign state    = state_q;
    assign done     = done_q;
    assign bout     = bout_q;
    assign alarm    = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4 and ALARM_TICKS=10.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_countdown_timer;

    logic       clk;
    logic       clr;
    logic       load;
    logic       start;
    logic       pause;
    logic [2:0] set_mt;
    logic [3:0] set_mo;
    logic [2:0] set_st;
    logic [3:0] set_so;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [1:0] state;
    logic       done;
    logic       bout;
    logic       alarm;

    int n_tests = 0;
    int n_fail  = 0;

    countdown_timer #(
        .TICK_DIV    (4),
        .ALARM_TICKS (10)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .load     (load),
        .start    (start),
        .pause    (pause),
        .set_mt   (set_mt),
        .set_mo   (set_mo),
        .set_st   (set_st),
        .set_so   (set_so),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .state    (state),
        .done     (done),
        .bout     (bout),
        .alarm    (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preset(input logic [2:0] mt, input logic [3:0] mo,
                          input logic [2:0] st, input logic [3:0] so);
        set_mt = mt;
        set_mo = mo;
        set_st = st;
        set_so = so;
    endtask

    initial begin
        int toggles;
        int exp_toggles;
        logic prev_alarm;

`ifdef COUNTDOWN_ALARM_EN
        exp_toggles = 10;
`else
        exp_toggles = 0;
`endif

        clr   = 1'b1;
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        preset(3'd0, 4'd0, 3'd0, 4'd0);
        cyc(3);
        chk("rst_digits", digits(), 16'h0000);
        chk("rst_state",  16'(state), 16'd0);
        chk("rst_done",   16'(done),  16'd0);
        chk("rst_bout",   16'(bout),  16'd0);
        chk("rst_alarm",  16'(alarm), 16'd0);
        clr = 1'b0;
        cyc(1);

        // Load 01:02 in IDLE.
        preset(3'd0, 4'd1, 3'd0, 4'd2);
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("load_digits", digits(), 16'h0102);
        chk("load_state",  16'(state), 16'd0);
        chk("load_bout",   16'(bout),  16'd0);

        // Borrow chain from 01:00 down to expiry.
        preset(3'd0, 4'd1, 3'd0, 4'd0);
        load = 1'b1;
        cyc(1);
        load  = 1'b0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("start_state", 16'(state), 16'd1);
        chk("start_digits", digits(), 16'h0100);
        cyc(3);
        chk("pre_tick_digits", digits(), 16'h0100);
        cyc(1);
        chk("first_tick_digits", digits(), 16'h0059);
        chk("first_tick_bout",   16'(bout), 16'd1);
        cyc(235);
        chk("last_sec_digits", digits(), 16'h0001);
        chk("last_sec_state",  16'(state), 16'd1);
        chk("last_sec_done",   16'(done),  16'd0);
        cyc(1);
        chk("expire_digits", digits(), 16'h0000);
        chk("expire_state",  16'(state), 16'd3);
        chk("expire_done",   16'(done),  16'd1);
        cyc(1);
        chk("done_pulse_end", 16'(done),  16'd0);
        chk("done_hold",      16'(state), 16'd3);

        // Alarm blink count while sitting in DONE.
        toggles    = 0;
        prev_alarm = alarm;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (alarm !== prev_alarm) toggles++;
            prev_alarm = alarm;
        end
        chk("alarm_toggles", 16'(toggles), 16'(exp_toggles));
        chk("alarm_final",   16'(alarm),   16'd0);
        chk("alarm_state",   16'(state),   16'd3);

        // Saturating load from DONE: 00:7(12) -> 00:59, back to IDLE.
        preset(3'd0, 4'd0, 3'd7, 4'd12);
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("sat_digits", digits(), 16'h0059);
        chk("sat_state",  16'(state), 16'd0);
        chk("sat_alarm",  16'(alarm), 16'd0);

        // Start at 00:00 goes straight to DONE.
        preset(3'd0, 4'd0, 3'd0, 4'd0);
        load = 1'b1;
        cyc(1);
        load  = 1'b0;
        start = 1'b1;
        cyc(1);
        chk("zero_start_state", 16'(state), 16'd3);
        chk("zero_start_done",  16'(done),  16'd1);
        cyc(1);
        start = 1'b0;
        chk("zero_done_end", 16'(done), 16'd0);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        chk("done_ignores_pause", 16'(state), 16'd3);

        // Pause/resume preserves the divider phase.
        preset(3'd0, 4'd0, 3'd0, 4'd5);
        load = 1'b1;
        cyc(1);
        load  = 1'b0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        chk("pause_state",  16'(state), 16'd2);
        chk("pause_digits", digits(), 16'h0005);
        cyc(10);
        chk("paused_digits", digits(), 16'h0005);
        chk("paused_state",  16'(state), 16'd2);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("resume_state",  16'(state), 16'd1);
        chk("resume_digits", digits(), 16'h0005);
        cyc(1);
        chk("resume_plus1", digits(), 16'h0005);
        cyc(1);
        chk("resume_plus2", digits(), 16'h0004);

        // Load and start are ignored while running.
        preset(3'd0, 4'd9, 3'd0, 4'd9);
        load  = 1'b1;
        start = 1'b1;
        cyc(1);
        load  = 1'b0;
        start = 1'b0;
        chk("run_ignore_load", digits(), 16'h0004);
        chk("run_ignore_state", 16'(state), 16'd1);

        // Pause beats start in RUN; load beats start in PAUSE.
        start = 1'b1;
        pause = 1'b1;
        cyc(1);
        start = 1'b0;
        pause = 1'b0;
        chk("prec_pause_state", 16'(state), 16'd2);
        preset(3'd2, 4'd3, 3'd0, 4'd0);
        load  = 1'b1;
        start = 1'b1;
        cyc(1);
        load  = 1'b0;
        start = 1'b0;
        chk("prec_load_state",  16'(state), 16'd0);
        chk("prec_load_digits", digits(), 16'h2300);

        // Async clear in the middle of a run.
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(4);
        chk("mid_run_digits", digits(), 16'h2259);
        chk("mid_run_bout",   16'(bout), 16'd0);
        #2;
        clr = 1'b1;
        #1;
        chk("async_clr_digits", digits(), 16'h0000);
        chk("async_clr_state",  16'(state), 16'd0);
        chk("async_clr_bout",   16'(bout),  16'd0);
        cyc(2);
        chk("clr_held_digits", digits(), 16'h0000);
        preset(3'd0, 4'd0, 3'd0, 4'd3);
        clr  = 1'b0;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("post_clr_load",  digits(), 16'h0003);
        chk("post_clr_state", 16'(state), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
